// File: rtl/fetch_queue.sv
// Fetch-to-align instruction queue: DEPTH-entry circular buffer of {pc, data, fault}
// with registered full back-pressure, head read straight from storage, and flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_data,
  input  logic             i_fault,
  output logic             o_stall,
  input  logic             i_stall,
  output logic             o_valid,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_data,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      data_mem  [DEPTH];
  logic             fault_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Full is decoded from the registered count only, so fetch never sees a path from align.
  assign o_stall = (count_q == CNT_W'(DEPTH));
  assign o_valid = (count_q != '0) && !i_flush;
  assign o_count = count_q;

  assign push = i_valid && !o_stall && !i_flush;
  assign pop  = o_valid && !i_stall;

  assign o_pc    = pc_mem[rd_ptr_q];
  assign o_data  = data_mem[rd_ptr_q];
  assign o_fault = fault_mem[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never reset; o_valid qualifies it.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= i_pc;
      data_mem[wr_ptr_q]  <= i_data;
      fault_mem[wr_ptr_q] <= i_fault;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): fill, drain, streaming wrap,
// full-with-pop, flush and asynchronous mid-operation reset.
module tb_fetch_queue;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_data;
  logic        i_fault;
  logic        o_stall;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_data;
  logic        o_fault;
  logic [2:0]  o_count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_pc    (i_pc),
    .i_data  (i_data),
    .i_fault (i_fault),
    .o_stall (o_stall),
    .i_stall (i_stall),
    .o_valid (o_valid),
    .o_pc    (o_pc),
    .o_data  (o_data),
    .o_fault (o_fault),
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] pc, input logic flt);
    i_valid = 1'b1;
    i_pc    = pc;
    i_data  = pc ^ 32'hA5A5_0000;
    i_fault = flt;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_pc    = '0;
    i_data  = '0;
    i_fault = 1'b0;
    i_stall = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // Fill with align stalled
    i_stall = 1'b1;
    present(32'h1000, 1'b0);
    #1;
    chk("empty_no_fallthrough", 32'(o_valid), 32'd0);
    tick();
    chk("fill1_valid", 32'(o_valid), 32'd1);
    chk("fill1_pc", o_pc, 32'h1000);
    present(32'h1004, 1'b0); tick();
    present(32'h1008, 1'b1); tick();
    present(32'h100C, 1'b0); tick();
    chk("fill4_count", 32'(o_count), 32'd4);
    chk("fill4_stall", 32'(o_stall), 32'd1);
    present(32'h1010, 1'b0); tick();
    chk("fill5_count", 32'(o_count), 32'd4);
    chk("hold_pc", o_pc, 32'h1000);

    // Drain in order
    i_valid = 1'b0;
    i_stall = 1'b0;
    #1;
    chk("drain0_pc", o_pc, 32'h1000);
    chk("drain0_data", o_data, 32'h1000 ^ 32'hA5A5_0000);
    tick();
    chk("drain0_stall_off", 32'(o_stall), 32'd0);
    chk("drain1_pc", o_pc, 32'h1004);
    tick();
    chk("drain2_pc", o_pc, 32'h1008);
    chk("drain2_fault", 32'(o_fault), 32'd1);
    tick();
    chk("drain3_pc", o_pc, 32'h100C);
    chk("drain3_fault", 32'(o_fault), 32'd0);
    tick();
    chk("drained_valid", 32'(o_valid), 32'd0);
    chk("drained_count", 32'(o_count), 32'd0);
    i_stall = 1'b1;
    tick();
    chk("empty_stall_ignored", 32'(o_count), 32'd0);

    // Streaming at count=2
    present(32'h4000, 1'b0); tick();
    present(32'h4004, 1'b0); tick();
    chk("stream_pre_count", 32'(o_count), 32'd2);
    i_stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      present(32'h4008 + 32'(4 * k), 1'b0);
      #1;
      chk($sformatf("stream%0d_pc", k), o_pc, 32'h4000 + 32'(4 * k));
      tick();
      chk($sformatf("stream%0d_count", k), 32'(o_count), 32'd2);
    end

    // Refill to full, then push+pop while full
    i_stall = 1'b1;
    present(32'h5000, 1'b0); tick();
    present(32'h5004, 1'b0); tick();
    chk("full_count", 32'(o_count), 32'd4);
    chk("full_head", o_pc, 32'h4028);
    present(32'h5008, 1'b0);
    i_stall = 1'b0;
    #1;
    chk("fullpop_stall", 32'(o_stall), 32'd1);
    tick();
    chk("fullpop_count", 32'(o_count), 32'd3);
    chk("fullpop_stall_off", 32'(o_stall), 32'd0);
    chk("fullpop_head", o_pc, 32'h402C);
    i_stall = 1'b1;
    tick();
    chk("fullpop_push_count", 32'(o_count), 32'd4);
    i_valid = 1'b0;
    i_stall = 1'b0;
    tick();
    chk("preflush_count", 32'(o_count), 32'd3);
    chk("preflush_head", o_pc, 32'h5000);

    // Flush with a word presented
    i_flush = 1'b1;
    present(32'h2000, 1'b0);
    #1;
    chk("flush_valid_same", 32'(o_valid), 32'd0);
    tick();
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_stall", 32'(o_stall), 32'd0);
    i_flush = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("postflush_valid", 32'(o_valid), 32'd0);
    tick();
    chk("postflush_count", 32'(o_count), 32'd0);

    // Asynchronous reset mid-operation
    i_stall = 1'b1;
    present(32'h6000, 1'b0); tick();
    present(32'h6004, 1'b0); tick();
    i_valid = 1'b0;
    chk("prerst_count", 32'(o_count), 32'd2);
    i_rst_n = 1'b0;
    #2;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_count", 32'(o_count), 32'd0);
    i_rst_n = 1'b1;
    present(32'h3000, 1'b0);
    tick();
    chk("postrst_valid", 32'(o_valid), 32'd1);
    chk("postrst_pc", o_pc, 32'h3000);
    chk("postrst_count", 32'(o_count), 32'd1);
    i_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter: CNT_W, $clog2(DEPTH)+1, width of o_count.
REQ-003 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: i_flush  input  1  writeback redirect; discard all queued entries.
REQ-006 Port: i_valid  input  1  fetch stage presents a fetched word this cycle.
REQ-007 Port: i_pc  input  32  program counter of the presented word.
REQ-008 Port: i_data  input  32  fetched instruction word.
REQ-009 Port: i_fault  input  1  fetch access fault for the presented word.
REQ-010 Port: o_stall  output  1  back-pressure to fetch; queue full.
REQ-011 Port: i_stall  input  1  back-pressure from align; head not consumed.
REQ-012 Port: o_valid  output  1  head entry valid toward align.
REQ-013 Port: o_pc  output  32  head entry PC.
REQ-014 Port: o_data  output  32  head entry instruction word.
REQ-015 Port: o_fault  output  1  head entry fault flag.
REQ-016 Port: o_count  output  CNT_W  number of occupied entries.

Function
REQ-017 Storage: DEPTH entries of {pc, data, fault}; read pointer, write pointer (log2 DEPTH bits, wrap modulo DEPTH) and occupancy count (0..DEPTH).
REQ-018 o_stall SHALL equal (count == DEPTH), derived from registered state only; no combinational path from i_stall or i_valid.
REQ-019 Push SHALL occur on an edge when i_valid=1, o_stall=0, i_flush=0; entry written at write pointer, write pointer +1.
REQ-020 o_valid SHALL equal (count != 0) and not i_flush.
REQ-021 o_pc/o_data/o_fault SHALL present the entry at the read pointer combinationally from storage; no fall-through, so an entry is visible to align no earlier than the cycle after its push (1-cycle minimum latency).
REQ-022 Pop SHALL occur on an edge when o_valid=1 and i_stall=0; read pointer +1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Full: push not accepted (o_stall=1) even if a pop occurs in the same cycle; the pop proceeds and o_stall deasserts the following cycle.
REQ-025 Empty: o_valid=0; i_stall is ignored; a push makes o_valid=1 the next cycle.
REQ-026 Flush SHALL take priority over push and pop: on the edge with i_flush=1, count, read pointer and write pointer return to 0; the word presented that cycle is dropped.
REQ-027 While i_flush=1, o_valid SHALL be 0 in that same cycle.
REQ-028 Head outputs SHALL hold stable while o_valid=1 and i_stall=1.
REQ-029 Words SHALL be delivered in push order with no loss or duplication absent flush.
REQ-030 o_count SHALL equal the registered occupancy count.

Reset
REQ-031 While i_rst_n=0, asynchronously: count, both pointers = 0; o_valid=0, o_stall=0, o_count=0.
REQ-032 Entry storage SHALL not require reset; o_pc/o_data/o_fault SHALL be don't-care while o_valid=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately; the first push after deassertion becomes the head.

Verification
REQ-034 Fill: DEPTH=4, i_stall=1, push pc 0x1000,0x1004,0x1008,0x100C -> o_count=4, o_stall=1 after 4th edge; 5th word (0x1010) not accepted.
REQ-035 Drain in order: from full, i_stall=0, i_valid=0 -> o_pc 0x1000,0x1004,0x1008,0x100C on consecutive cycles, then o_valid=0, o_count=0.
REQ-036 Streaming: count=2, i_valid=1 and i_stall=0 each cycle for 10 cycles -> o_count stays 2, pointers wrap, sequence preserved.
REQ-037 Full-with-pop: count=4, i_valid=1, i_stall=0 -> that edge: pop only, count=3; next cycle o_stall=0, push accepted.
REQ-038 Flush: count=3, i_flush=1 with i_valid=1 (pc 0x2000) -> o_valid=0 same cycle; next cycle count=0, o_stall=0; 0x2000 not enqueued.
REQ-039 Reset mid-operation: count=2, drive i_rst_n=0 between edges -> o_valid=0 and o_count=0 without a clock edge; after release, push 0x3000 -> o_pc=0x3000 next cycle.
